iter_muldiv: RTL

//   Iterative 16-bit unsigned multiply/divide unit. It sits beside the ALU, downstream of the

---
 rtl/iter_muldiv.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/iter_muldiv.sv
// Iterative 16-bit unsigned multiply/divide unit that feeds the register file write port.
// One shift-add or restoring-divide iteration per clock; the result is written back on Done.
//
// state  | meaning
// S_IDLE | waiting for Start; Result/ResultReg hold the last value
// S_RUN  | one iteration per clock, count_q = 0 .. WIDTH-1
// S_DONE | one-cycle Done/RegWre pulse
module iter_muldiv #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [WIDTH-1:0]  OpA,
  input  logic [WIDTH-1:0]  OpB,
  input  logic [REG_AW-1:0] DstReg,
  output logic              Busy,
  output logic              Done,
  output logic              RegWre,
  output logic [REG_AW-1:0] ResultReg,
  output logic [WIDTH-1:0]  Result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [REG_AW-1:0]   dst_q, dst_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [REG_AW-1:0]   result_reg_q, result_reg_d;

  logic [WIDTH:0]      mul_sum;
  logic [2*WIDTH-1:0]  mul_next;
  logic [WIDTH:0]      div_shifted;
  logic [WIDTH-1:0]    div_diff;
  logic                div_neg;
  logic [2*WIDTH-1:0]  div_next_acc;
  logic [WIDTH-1:0]    div_next_rem;

  // a_q holds the multiplicand (MUL) or divisor (DIV); acc_q low half holds the
  // multiplier (MUL) or the dividend shifting out while quotient bits shift in (DIV).
  always_comb begin
    mul_sum      = '0;
    mul_next     = '0;
    div_shifted  = '0;
    div_diff     = '0;
    div_neg      = 1'b0;
    div_next_acc = '0;
    div_next_rem = '0;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    div_shifted  = {rem_q, acc_q[WIDTH-1]};
    div_neg      = (div_shifted < {1'b0, a_q});
    div_diff     = div_shifted[WIDTH-1:0] - a_q;
    div_next_acc = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_neg};
    div_next_rem = div_neg ? div_shifted[WIDTH-1:0] : div_diff;
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    op_d         = op_q;
    a_d          = a_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    dst_d        = dst_q;
    result_d     = result_q;
    result_reg_d = result_reg_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RUN;
          count_d = '0;
          op_d    = Op;
          a_d     = Op[1] ? OpB : OpA;
          acc_d   = {{WIDTH{1'b0}}, (Op[1] ? OpA : OpB)};
          rem_d   = '0;
          dst_d   = DstReg;
        end
      end
      S_RUN: begin
        count_d = count_q + 1'b1;
        if (op_q[1]) begin
          acc_d = div_next_acc;
          rem_d = div_next_rem;
        end else begin
          acc_d = mul_next;
        end
        if (count_q == CW'(WIDTH-1)) begin
          state_d      = S_DONE;
          result_reg_d = dst_q;
          case (op_q)
            OP_MUL:  result_d = acc_d[WIDTH-1:0];
            OP_MULH: result_d = acc_d[2*WIDTH-1:WIDTH];
            OP_DIV:  result_d = acc_d[WIDTH-1:0];
            default: result_d = rem_d;
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      op_q         <= '0;
      a_q          <= '0;
      acc_q        <= '0;
      rem_q        <= '0;
      dst_q        <= '0;
      result_q     <= '0;
      result_reg_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      op_q         <= op_d;
      a_q          <= a_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      dst_q        <= dst_d;
      result_q     <= result_d;
      result_reg_q <= result_reg_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign RegWre    = Done;
  assign Result    = result_q;
  assign ResultReg = result_reg_q;

endmodule
